// File: rtl/instr_encoder.sv
// Encodes R/lw/sw/beq requests into 32-bit words and streams them to an
// instruction memory with sequential byte addresses. Optional macro: ENC_FUNCT_CHECK_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        full,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       enc;
  logic              accept, hs, bad_funct, emit_acc, cnt_last;

  always_comb begin
    enc = '0;
    unique case (in_kind)
      2'b00: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
      2'b01: enc = {6'b100011, in_rs, in_rt, in_imm};
      2'b10: enc = {6'b101011, in_rs, in_rt, in_imm};
      2'b11: enc = {6'b000100, in_rs, in_rt, in_imm};
      default: enc = '0;
    endcase
  end

`ifdef ENC_FUNCT_CHECK_EN
  always_comb begin
    bad_funct = 1'b0;
    if (in_kind == 2'b00) begin
      unique case (in_funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: bad_funct = 1'b0;
        default:                           bad_funct = 1'b1;
      endcase
    end
  end
`else
  assign bad_funct = 1'b0;
`endif

  assign out_valid = (state_q == EMIT);
  assign full      = (state_q == FULL);
  assign in_ready  = rst_n & ~full & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign emit_acc  = accept & ~bad_funct;
  assign cnt_last  = (cnt_q == {ADDR_W{1'b1}});
  assign out_instr = instr_q;
  assign out_addr  = {{(30-ADDR_W){1'b0}}, cnt_q, 2'b00};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    if (emit_acc) instr_d = enc;
    // The last slot saturates into FULL instead of wrapping the counter.
    if (hs && !cnt_last) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: if (emit_acc) state_d = EMIT;
      EMIT: begin
        if (hs) begin
          if (cnt_last)      state_d = FULL;
          else if (emit_acc) state_d = EMIT;
          else               state_d = IDLE;
        end
      end
      FULL:    state_d = FULL;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

`ifdef ENC_FUNCT_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = accept & bad_funct & ~clear;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_W=2) with an in-order scoreboard of
// expected {instr, addr} pairs pushed on accept and popped on output handshake.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, full, err;
  logic [1:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [31:0] out_instr, out_addr;

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [31:0] cur_exp;
  logic [63:0] sb_q[$];
  logic [63:0] ent;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .full(full), .err(err)
  );

  function automatic logic [31:0] encode(input logic [1:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm);
    logic [5:0] op;
    op = (k == 2'd1) ? 6'h23 : (k == 2'd2) ? 6'h2B : (k == 2'd3) ? 6'h04 : 6'h00;
    if (k == 2'd0) return {op, rs, rt, rd, 5'd0, fn};
    return {op, rs, rt, imm};
  endfunction

  function automatic bit funct_rejected(input logic [1:0] k, input logic [5:0] fn);
`ifdef ENC_FUNCT_CHECK_EN
    return (k == 2'd0) && !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm, input logic [31:0] exp);
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = fn; in_imm = imm; cur_exp = exp;
  endtask

  task automatic flush();
    sb_q.delete();
    wr_cnt = 0;
  endtask

  // Samples at the falling edge: pops on a pending handshake, pushes on a pending accept.
  task automatic tick();
    @(negedge clk);
    if (rst_n && !clear && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_output", out_instr, 32'hxxxxxxxx);
      end else begin
        ent = sb_q.pop_front();
        chk("sb_instr", out_instr, ent[63:32]);
        chk("sb_addr", out_addr, ent[31:0]);
      end
    end
    if (rst_n && !clear && in_valid && in_ready && !funct_rejected(in_kind, in_funct)) begin
      sb_q.push_back({cur_exp, 32'(wr_cnt * 4)});
      wr_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] k; logic [4:0] a, b, c; logic [5:0] f; logic [15:0] im;
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
    send(2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    rst_n = 1'b1; out_ready = 1'b1;
    send(2'd1, 5'd2, 5'd8, 5'd0, 6'd0, 16'h0004, 32'h8C480004); tick();
    chk("lat1_valid", {31'd0, out_valid}, 32'd1);
    send(2'd2, 5'd2, 5'd9, 5'd0, 6'd0, 16'h0008, 32'hAC490008); tick();
    send(2'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE, 32'h1022FFFE); tick();
    in_valid = 1'b0; tick();
    chk("idle_after_burst", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    send(2'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 32'h00221820); tick();
    for (int unsigned i = 0; i < 3; i++) begin
      send(2'd1, 5'd31, 5'd31, 5'd0, 6'd0, 16'hDEAD, 32'hBAD0BAD0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_instr", out_instr, 32'h00221820);
      chk("stall_addr", out_addr, 32'h0000000C);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("full_after_4", {31'd0, full}, 32'd1);
    chk("one_handshake", {31'd0, out_valid}, 32'd0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);

    clear = 1'b1; tick(); clear = 1'b0; flush();
    chk("clear_full", {31'd0, full}, 32'd0);
    chk("clear_addr", out_addr, 32'd0);

    for (int unsigned i = 0; i < 4; i++) begin
      k = 2'($urandom_range(1, 3)); a = 5'($urandom); b = 5'($urandom);
      c = 5'($urandom); im = 16'($urandom); f = 6'h22;
      send(k, a, b, c, f, im, encode(k, a, b, c, f, im));
      tick();
    end
    in_valid = 1'b0; tick();
    chk("stream_full", {31'd0, full}, 32'd1);
    chk("stream_in_ready", {31'd0, in_ready}, 32'd0);
    send(2'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 32'hBAD0BAD0); tick();
    chk("full_no_valid", {31'd0, out_valid}, 32'd0);

    clear = 1'b1; tick(); clear = 1'b0; flush();
    send(2'd0, 5'd4, 5'd5, 5'd6, 6'h2A, 16'd0, 32'hBAD0BAD0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_wins", {31'd0, out_valid}, 32'd0);
    send(2'd0, 5'd4, 5'd5, 5'd6, 6'h25, 16'd0, 32'h00853025); tick();
    in_valid = 1'b0; tick();

    send(2'd0, 5'd1, 5'd2, 5'd3, 6'h3F, 16'd0, 32'h0022183F); tick();
    in_valid = 1'b0;
`ifdef ENC_FUNCT_CHECK_EN
    chk("funct_err", {31'd0, err}, 32'd1);
    chk("funct_no_valid", {31'd0, out_valid}, 32'd0);
    chk("funct_addr", out_addr, 32'h00000004);
    tick();
    chk("funct_err_pulse", {31'd0, err}, 32'd0);
`else
    chk("funct_err_tied", {31'd0, err}, 32'd0);
    chk("funct_valid", {31'd0, out_valid}, 32'd1);
    tick();
`endif

    out_ready = 1'b0;
    send(2'd1, 5'd7, 5'd7, 5'd0, 6'd0, 16'h1234, 32'h8CE71234); tick();
    in_valid = 1'b0; rst_n = 1'b0; tick(); flush();
    rst_n = 1'b1; out_ready = 1'b1; tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_instr", out_instr, 32'd0);
    chk("midrst_addr", out_addr, 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
